rx_arbiter_fifo: RTL and testbench

- Input stage of a switch: accepts flits from all PORTS_NUM+1 inbound links (PORTS_NUM neighbour links plus the local core injection port).
- Round-robin arbitration at packet granularity (wormhole lock), so flits of different packets never interleave in the queue.
- Buffers flits in a first-word-fall-through queue that the switch's transceiver drains through the mem_empty / data / mem_readed interface.

---
 rtl/noc_pkg.sv | 19 +
 rtl/rx_arbiter_fifo_if.sv | 33 +++
 rtl/flit_fifo.sv | 59 +++++
 rtl/rx_arbiter_fifo.sv | 130 +++++++++++++
 tb/tb_rx_arbiter_fifo.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout helpers and the input-arbiter state encoding.
// Optional feature macro used by this slice: RX_PKT_CNT_EN.
package noc_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int bus_size(input int data_size, input int addr_size);
    return data_size + addr_size + 1;
  endfunction

  // The last-flit flag sits directly above the destination address.
  function automatic int last_bit(input int addr_size);
    return addr_size;
  endfunction

endpackage

// File: rtl/rx_arbiter_fifo_if.sv
// Inbound links, acknowledge lines and transceiver-side queue port of the switch input stage.
// RX_PKT_CNT_EN adds the pkt_cnt observation port.
interface rx_arbiter_fifo_if
  import noc_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4
);
  localparam int BUS_SIZE = bus_size(DATA_SIZE, ADDR_SIZE);
  localparam int NPORT    = PORTS_NUM + 1;

  logic [NPORT-1:0]          wr_ready_in;
  logic [BUS_SIZE*NPORT-1:0] data_in;
  logic [NPORT-1:0]          r_ready_out;
  logic                      mem_readed;
  logic                      mem_empty;
  logic [BUS_SIZE-1:0]       data_o;
`ifdef RX_PKT_CNT_EN
  logic [15:0]               pkt_cnt;

  modport master (output wr_ready_in, data_in, mem_readed,
                  input  r_ready_out, mem_empty, data_o, pkt_cnt);
  modport slave  (input  wr_ready_in, data_in, mem_readed,
                  output r_ready_out, mem_empty, data_o, pkt_cnt);
`else
  modport master (output wr_ready_in, data_in, mem_readed,
                  input  r_ready_out, mem_empty, data_o);
  modport slave  (input  wr_ready_in, data_in, mem_readed,
                  output r_ready_out, mem_empty, data_o);
`endif

endinterface

// File: rtl/flit_fifo.sv
// First-word-fall-through flit queue; head is a combinational read of the oldest entry.
// Independent of RX_PKT_CNT_EN.
module flit_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Masked so the head reads zero whenever nothing valid is queued.
  assign head    = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rx_arbiter_fifo.sv
// Switch input stage: packet-locked round-robin arbiter over all inbound links feeding a flit queue.
// RX_PKT_CNT_EN adds a 16-bit wrapping count of accepted last flits on pkt_cnt.
module rx_arbiter_fifo
  import noc_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4,
  parameter int DEPTH     = 8
) (
  input logic              clk,
  input logic              a_rst,
  rx_arbiter_fifo_if.slave bus
);
  localparam int BUS_SIZE = bus_size(DATA_SIZE, ADDR_SIZE);
  localparam int NPORT    = PORTS_NUM + 1;
  localparam int PW       = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int LB       = last_bit(ADDR_SIZE);

  arb_state_t          state_q;
  arb_state_t          state_d;
  logic [PW-1:0]       rr_ptr_q;
  logic [PW-1:0]       lock_port_q;
  logic [NPORT-1:0]    ack_q;
  logic [NPORT-1:0]    eligible;
  logic [PW-1:0]       scan_idx;
  logic [PW-1:0]       grant_port;
  logic                grant_vld;
  logic [BUS_SIZE-1:0] grant_flit;
  logic                grant_last;
  logic                accept;
  logic                fifo_full;
  logic                fifo_empty;
  logic [BUS_SIZE-1:0] fifo_head;

  // Only a clean 1 counts: floating or unknown edge-port inputs are never granted.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NPORT; p++) begin
      eligible[p] = (bus.wr_ready_in[p] === 1'b1) && !ack_q[p];
    end
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= PW'(PORTS_NUM);
      lock_port_q <= '0;
      ack_q       <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= accept ? (NPORT'(1) << grant_port) : '0;
      if (accept && (state_q == ARB_IDLE)) begin
        rr_ptr_q    <= grant_port;
        lock_port_q <= grant_port;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = grant_last ? ARB_IDLE : ARB_LOCKED;
    end
  end

  // Descending scan so the port closest after rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_vld  = 1'b0;
    grant_port = '0;
    scan_idx   = '0;
    if (state_q == ARB_LOCKED) begin
      grant_vld  = eligible[lock_port_q];
      grant_port = lock_port_q;
    end else begin
      for (int i = NPORT; i >= 1; i--) begin
        scan_idx = PW'((int'(rr_ptr_q) + i) % NPORT);
        if (eligible[scan_idx]) begin
          grant_vld  = 1'b1;
          grant_port = scan_idx;
        end
      end
    end
  end

  always_comb begin
    grant_flit = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (grant_port == PW'(p)) begin
        grant_flit = bus.data_in[p*BUS_SIZE +: BUS_SIZE];
      end
    end
  end

  assign grant_last = grant_flit[LB];
  assign accept     = grant_vld && !fifo_full;

  flit_fifo #(
    .WIDTH (BUS_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .a_rst     (a_rst),
    .push      (accept),
    .push_data (grant_flit),
    .pop       (bus.mem_readed),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign bus.r_ready_out = ack_q;
  assign bus.mem_empty   = fifo_empty;
  assign bus.data_o      = fifo_head;

`ifdef RX_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (a_rst) begin
      pkt_cnt_q <= '0;
    end else if (accept && grant_last) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign bus.pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_rx_arbiter_fifo.sv
// Bench for rx_arbiter_fifo: directed scenarios plus random traffic against a packet-level reference model.
// Checks pkt_cnt as well when RX_PKT_CNT_EN is defined.
module tb_rx_arbiter_fifo;
  import noc_pkg::*;

  localparam int DATA_SIZE = 32;
  localparam int ADDR_SIZE = 4;
  localparam int PORTS_NUM = 4;
  localparam int DEPTH     = 8;
  localparam int NP        = PORTS_NUM + 1;
  localparam int BUS       = bus_size(DATA_SIZE, ADDR_SIZE);
  localparam int LB        = last_bit(ADDR_SIZE);

  typedef logic [BUS-1:0] flit_t;

  logic clk   = 1'b0;
  logic a_rst = 1'b1;

  rx_arbiter_fifo_if #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .PORTS_NUM(PORTS_NUM)) bus ();

  rx_arbiter_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE),
    .PORTS_NUM (PORTS_NUM),
    .DEPTH     (DEPTH)
  ) dut (
    .clk   (clk),
    .a_rst (a_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  flit_t src_q [NP][$];
  bit    src_z [NP];
  flit_t sb_q [$];
  int    ack_log [$];
  bit    gap_en;
  int    serial;

  // Reference model: who owns the queue, which port was served last, what is buffered.
  int            m_rr;
  int            m_lport;
  int            m_cnt;
  int            m_pkt;
  bit            m_locked;
  logic [NP-1:0] m_ack;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic flit_t mk(input logic [DATA_SIZE-1:0] pl, input bit last,
                               input logic [ADDR_SIZE-1:0] addr);
    return {pl, last, addr};
  endfunction

  task automatic add_pkt(input int p, input int len);
    for (int k = 0; k < len; k++) begin
      serial++;
      src_q[p].push_back(mk({8'(p), 24'(serial)}, (k == len - 1), 4'($urandom)));
    end
  endtask

  task automatic do_reset();
    a_rst           = 1'b1;
    bus.wr_ready_in = '0;
    bus.data_in     = '0;
    bus.mem_readed  = 1'b0;
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      src_z[p] = 1'b0;
    end
    sb_q.delete();
    m_rr     = PORTS_NUM;
    m_lport  = 0;
    m_cnt    = 0;
    m_pkt    = 0;
    m_locked = 1'b0;
    m_ack    = '0;
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    ack_log.delete();
  endtask

  // One clock: check the DUT against the model, drive the senders, advance the model to the next edge.
  task automatic step(input bit rd);
    logic [NP-1:0] elig;
    int            g;
    int            cnt0;
    flit_t         f;
    chk("r_ready_out", 64'(bus.r_ready_out), 64'(m_ack));
    chk("mem_empty", 64'(bus.mem_empty), 64'(m_cnt == 0));
`ifdef RX_PKT_CNT_EN
    chk("pkt_cnt", 64'(bus.pkt_cnt), 64'(m_pkt));
`endif
    for (int p = 0; p < NP; p++) begin
      if (bus.r_ready_out[p] === 1'b1) ack_log.push_back(p);
    end
    for (int p = 0; p < NP; p++) begin
      if (m_ack[p]) void'(src_q[p].pop_front());
    end
    for (int p = 0; p < NP; p++) begin
      if (src_z[p]) bus.wr_ready_in[p] = 1'bz;
      else if (src_q[p].size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) bus.wr_ready_in[p] = 1'b1;
      else bus.wr_ready_in[p] = 1'b0;
      bus.data_in[p*BUS +: BUS] = (src_q[p].size() > 0) ? src_q[p][0] : '0;
    end
    bus.mem_readed = rd;

    for (int p = 0; p < NP; p++) begin
      elig[p] = (bus.wr_ready_in[p] === 1'b1) && !m_ack[p] && (!m_locked || p == m_lport);
    end
    g = -1;
    for (int i = 1; i <= NP && g < 0; i++) begin
      if (elig[(m_rr + i) % NP]) g = (m_rr + i) % NP;
    end
    cnt0  = m_cnt;
    m_ack = '0;
    if (g >= 0 && cnt0 < DEPTH) begin
      f = src_q[g][0];
      sb_q.push_back(f);
      m_ack[g] = 1'b1;
      if (!m_locked) m_rr = g;
      if (f[LB]) begin
        m_locked = 1'b0;
        m_pkt    = (m_pkt + 1) % 65536;
      end else begin
        m_locked = 1'b1;
        m_lport  = g;
      end
      m_cnt++;
    end
    if (rd && cnt0 > 0) m_cnt--;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every pop the DUT performs must hand over the oldest expected flit.
  initial begin
    flit_t exp_f;
    forever begin
      @(negedge clk);
      if (a_rst === 1'b0 && bus.mem_readed === 1'b1 && bus.mem_empty === 1'b0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h expected no flit at %0t", bus.data_o, $time);
        end else begin
          exp_f = sb_q.pop_front();
          chk("data_o_pop", 64'(bus.data_o), 64'(exp_f));
        end
      end
    end
  end

  initial begin
    int exp2 [6] = '{0, 0, 0, 3, 3, 3};
    int exp3 [6] = '{0, 1, 2, 3, 4, 0};
    int n1;
    int n4;
    serial         = 0;
    gap_en         = 1'b0;
    bus.wr_ready_in = '0;
    bus.data_in    = '0;
    bus.mem_readed = 1'b0;

    // Single-flit packet on port 2.
    do_reset();
    chk("rst_r_ready_out", 64'(bus.r_ready_out), 64'(0));
    chk("rst_mem_empty", 64'(bus.mem_empty), 64'(1));
    chk("rst_data_o", 64'(bus.data_o), 64'(0));
    src_q[2].push_back(mk(32'h1, 1'b1, 4'h3));
    step(1'b0);
    chk("p1_ack", 64'(bus.r_ready_out), 64'(5'b00100));
    chk("p1_not_empty", 64'(bus.mem_empty), 64'(0));
    chk("p1_data", 64'(bus.data_o), 64'h33);
    step(1'b1);
    chk("p1_ack_clear", 64'(bus.r_ready_out), 64'(0));
    chk("p1_empty", 64'(bus.mem_empty), 64'(1));
    repeat (2) step(1'b1);

    // Two 3-flit packets contending: no interleaving.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      src_q[0].push_back(mk(32'hA0 + 32'(k), (k == 2), 4'h1));
      src_q[3].push_back(mk(32'hB0 + 32'(k), (k == 2), 4'h2));
    end
    repeat (14) step(1'b1);
    chk("p2_len", 64'(ack_log.size()), 64'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < ack_log.size()) chk("p2_order", 64'(ack_log[i]), 64'(exp2[i]));
    end

    // All ports streaming single-flit packets: strict rotation.
    do_reset();
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < 4; k++) add_pkt(p, 1);
    end
    repeat (25) step(1'b1);
    chk("p3_len", 64'(ack_log.size()), 64'(20));
    for (int i = 0; i < 6; i++) begin
      if (i < ack_log.size()) chk("p3_order", 64'(ack_log[i]), 64'(exp3[i]));
    end

    // Fill without popping: exactly DEPTH accepted, one pop frees one slot.
    do_reset();
    for (int p = 0; p < NP; p++) begin
      add_pkt(p, 1);
      add_pkt(p, 1);
    end
    repeat (20) step(1'b0);
    chk("p4_accepted", 64'(ack_log.size()), 64'(DEPTH));
    chk("p4_not_empty", 64'(bus.mem_empty), 64'(0));
    step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("p4_after_pop", 64'(ack_log.size()), 64'(DEPTH + 1));
    repeat (30) step(1'b1);

    // Floating port 1 must never be served; port 4 goes through.
    do_reset();
    src_z[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      add_pkt(1, 1);
      add_pkt(4, 1);
    end
    repeat (12) step(1'b1);
    n1 = 0;
    n4 = 0;
    foreach (ack_log[i]) begin
      if (ack_log[i] == 1) n1++;
      if (ack_log[i] == 4) n4++;
    end
    chk("p5_port1_acks", 64'(n1), 64'(0));
    chk("p5_port4_acks", 64'(n4), 64'(3));

    // Reset in the middle of a locked packet.
    do_reset();
    add_pkt(2, 1);
    add_pkt(0, 3);
    repeat (3) step(1'b0);
    do_reset();
    chk("p6_mem_empty", 64'(bus.mem_empty), 64'(1));
    chk("p6_r_ready_out", 64'(bus.r_ready_out), 64'(0));
`ifdef RX_PKT_CNT_EN
    chk("p6_pkt_cnt", 64'(bus.pkt_cnt), 64'(0));
`endif
    add_pkt(3, 1);
    repeat (4) step(1'b1);
    chk("p6_idle_grant_cnt", 64'(ack_log.size()), 64'(1));
    if (ack_log.size() > 0) chk("p6_idle_grant_port", 64'(ack_log[0]), 64'(3));

    // Random traffic with sender gaps and random draining.
    do_reset();
    gap_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (src_q[p].size() < 4 && $urandom_range(0, 9) == 0) add_pkt(p, $urandom_range(1, 3));
      end
      step($urandom_range(0, 3) != 0);
    end
    gap_en = 1'b0;
    repeat (200) step(1'b1);
    chk("final_empty", 64'(bus.mem_empty), 64'(1));
    chk("final_scoreboard", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
